// File: rtl/sync_series_carry_updown_counter_if.sv
// sync_series_carry_updown_counter_if: control and status bundle for the series-carry up/down counter
interface sync_series_carry_updown_counter_if #(parameter int WIDTH = 4);
  logic en, up_dn, load;
  logic [WIDTH-1:0] load_val, out;
  logic tc, wrap;
  modport master (output en, up_dn, load, load_val, input out, tc, wrap);
  modport slave (input en, up_dn, load, load_val, output out, tc, wrap);
endinterface

// File: rtl/sync_series_carry_updown_counter.sv
// sync_series_carry_updown_counter: T-flop series-carry up/down counter with load, modulus and wrap flag; SERIES_CNT_SATURATE_EN selects saturating mode
module sync_series_carry_updown_counter #(
  parameter int WIDTH = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input logic clk,
  input logic rst_n,
  sync_series_carry_updown_counter_if.slave bus
);
  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_cfg
    $error("sync_series_carry_updown_counter: WIDTH must be 1..32 and MODULUS 2..2**WIDTH");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
  logic [WIDTH-1:0] out_q, out_d, tog_up, tog_dn, chain, lv_clamped;
  logic wrap_q, wrap_d, at_term;
  assign tog_up[0] = 1'b1;
  assign tog_dn[0] = 1'b1;
  for (genvar g = 1; g < WIDTH; g++) begin : g_chain
    assign tog_up[g] = &out_q[g-1:0];
    assign tog_dn[g] = ~|out_q[g-1:0];
  end
  // next state: load beats count; the terminal value overrides the toggle chain
  always_comb begin
    at_term = bus.up_dn ? (out_q == MAX) : (out_q == '0);
    chain = out_q ^ (bus.up_dn ? tog_up : tog_dn);
    lv_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;
`ifdef SERIES_CNT_SATURATE_EN
    out_d = bus.load ? lv_clamped : (~bus.en | at_term) ? out_q : chain;
    wrap_d = 1'b0;
`else
    out_d = bus.load ? lv_clamped : ~bus.en ? out_q : at_term ? (bus.up_dn ? '0 : MAX) : chain;
    wrap_d = bus.en & ~bus.load & at_term;
`endif
  end
  // count and wrap-pulse registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q <= out_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.out = out_q;
  assign bus.wrap = wrap_q;
  assign bus.tc = bus.en & at_term;
endmodule
